// File: rtl/register_file_16x20_pkg.sv
// Shared constants and state encoding for the 16x20 register file.
// Widths match the downstream multiplexor_16x20_4_20.
`timescale 1ns/1ps
package register_file_16x20_pkg;
    localparam int unsigned WIDTH  = 20;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        StIdle  = 1'b0,
        StSweep = 1'b1
    } state_e;
endpackage

// File: rtl/register_file_16x20_cell.sv
// Single 20-bit storage cell with write enable and asynchronous active-high reset.
`timescale 1ns/1ps
module reg_cell_20
    import register_file_16x20_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_file_16x20.sv
// Sixteen-entry 20-bit register file: one handshaked write port, parallel outputs,
// and a one-register-per-cycle clear sweep.
`timescale 1ns/1ps
module register_file_16x20
    import register_file_16x20_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              clr,
    output logic              busy,
    output logic [WIDTH-1:0]  out0,
    output logic [WIDTH-1:0]  out1,
    output logic [WIDTH-1:0]  out2,
    output logic [WIDTH-1:0]  out3,
    output logic [WIDTH-1:0]  out4,
    output logic [WIDTH-1:0]  out5,
    output logic [WIDTH-1:0]  out6,
    output logic [WIDTH-1:0]  out7,
    output logic [WIDTH-1:0]  out8,
    output logic [WIDTH-1:0]  out9,
    output logic [WIDTH-1:0]  out10,
    output logic [WIDTH-1:0]  out11,
    output logic [WIDTH-1:0]  out12,
    output logic [WIDTH-1:0]  out13,
    output logic [WIDTH-1:0]  out14,
    output logic [WIDTH-1:0]  out15
);

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              busy_q;
    logic              sweeping;
    logic              wr_fire;
    logic [WIDTH-1:0]  cell_d;
    logic [WIDTH-1:0]  q [DEPTH];

    assign sweeping = (state_q == StSweep);
    // clr takes priority over a pending write in IDLE
    assign wr_ready = (state_q == StIdle) && !clr;
    assign wr_fire  = wr_valid && wr_ready;
    assign cell_d   = sweeping ? '0 : wr_data;
    assign busy     = busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (clr) begin
                        state_q <= StSweep;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StSweep: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == LAST_PTR) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        logic en;
        assign en = (wr_fire && (wr_addr == ADDR_W'(i))) || (sweeping && (ptr_q == ADDR_W'(i)));

        reg_cell_20 u_cell (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .d   (cell_d),
            .q   (q[i])
        );
    end

    assign out0  = q[0];
    assign out1  = q[1];
    assign out2  = q[2];
    assign out3  = q[3];
    assign out4  = q[4];
    assign out5  = q[5];
    assign out6  = q[6];
    assign out7  = q[7];
    assign out8  = q[8];
    assign out9  = q[9];
    assign out10 = q[10];
    assign out11 = q[11];
    assign out12 = q[12];
    assign out13 = q[13];
    assign out14 = q[14];
    assign out15 = q[15];

endmodule

// File: tb/tb_register_file_16x20.sv
// Self-checking bench for register_file_16x20: vector table, hand-written sweep/reset
// sequences and randomized traffic against an array-based reference model.
`timescale 1ns/1ps
module tb_register_file_16x20;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_addr;
    logic [19:0] wr_data;
    logic        clr;
    logic        busy;
    logic [19:0] outs [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    register_file_16x20 dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .clr      (clr),
        .busy     (busy),
        .out0     (outs[0]),
        .out1     (outs[1]),
        .out2     (outs[2]),
        .out3     (outs[3]),
        .out4     (outs[4]),
        .out5     (outs[5]),
        .out6     (outs[6]),
        .out7     (outs[7]),
        .out8     (outs[8]),
        .out9     (outs[9]),
        .out10    (outs[10]),
        .out11    (outs[11]),
        .out12    (outs[12]),
        .out13    (outs[13]),
        .out14    (outs[14]),
        .out15    (outs[15])
    );

    // Reference model: register contents plus "clears still owed" by an active sweep.
    logic [19:0] m_reg [16];
    int          m_left;   // registers remaining to clear; 0 means idle
    int          m_next;   // next register index the sweep clears

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %05h, expected %05h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = '0;
        m_left = 0;
        m_next = 0;
    endtask

    task automatic check_all();
        for (int i = 0; i < 16; i++) check($sformatf("out%0d", i), outs[i], m_reg[i]);
        check("busy", 20'(busy), 20'(m_left != 0));
        check("wr_ready", 20'(wr_ready), 20'((m_left == 0) && !clr));
    endtask

    // Advance one clock: update the model from the pre-edge inputs, then compare.
    task automatic tick();
        if (m_left != 0) begin
            m_reg[m_next] = '0;
            m_next++;
            m_left--;
        end else if (clr) begin
            m_left = 16;
            m_next = 0;
        end else if (wr_valid) begin
            m_reg[wr_addr] = wr_data;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [19:0] d, input logic c);
        wr_valid = v;
        wr_addr  = a;
        wr_data  = d;
        clr      = c;
    endtask

    // Pulse clr for one cycle, then count the cycles busy stays high.
    task automatic sweep_and_count(output int cnt);
        int guard;
        drive(1'b0, 4'd0, 20'd0, 1'b1);
        tick();
        clr   = 1'b0;
        cnt   = 0;
        guard = 0;
        while (busy && guard < 40) begin
            tick();
            cnt++;
            guard++;
        end
    endtask

    typedef struct {
        logic        v;
        logic [3:0]  a;
        logic [19:0] d;
        logic        c;
        logic        exp_ready;  // combinational wr_ready before the edge
        logic [3:0]  sel;        // downstream mux address to inspect after the edge
        logic [19:0] exp_val;
        logic        exp_busy;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int cnt;
        logic [19:0] held;

        vecs[0] = '{1'b1, 4'd3,  20'hABCDE, 1'b0, 1'b1, 4'd3,  20'hABCDE, 1'b0};
        vecs[1] = '{1'b1, 4'd15, 20'h12345, 1'b0, 1'b1, 4'd15, 20'h12345, 1'b0};
        vecs[2] = '{1'b0, 4'd3,  20'hFFFFF, 1'b0, 1'b1, 4'd3,  20'hABCDE, 1'b0};
        vecs[3] = '{1'b1, 4'd0,  20'h00001, 1'b0, 1'b1, 4'd0,  20'h00001, 1'b0};
        vecs[4] = '{1'b1, 4'd4,  20'h80000, 1'b0, 1'b1, 4'd5,  20'h00000, 1'b0};
        vecs[5] = '{1'b1, 4'd5,  20'h00F0F, 1'b1, 1'b0, 4'd5,  20'h00000, 1'b1};

        // Power-on reset
        rst = 1'b1;
        drive(1'b0, 4'd0, 20'd0, 1'b0);
        m_reset();
        #12;
        check_all();
        @(posedge clk);
        #1 rst = 1'b0;

        // Table: writes, idle cycle, and clr colliding with a write
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].c);
            #1;
            check($sformatf("vec%0d_ready", i), 20'(wr_ready), 20'(vecs[i].exp_ready));
            tick();
            check($sformatf("vec%0d_mux", i), outs[vecs[i].sel], vecs[i].exp_val);
            check($sformatf("vec%0d_busy", i), 20'(busy), 20'(vecs[i].exp_busy));
        end
        drive(1'b0, 4'd0, 20'd0, 1'b0);
        for (int g = 0; g < 40 && m_left != 0; g++) tick();

        // Randomized traffic with occasional clears
        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 20'($urandom),
                  ($urandom_range(0, 24) == 0));
            tick();
        end
        drive(1'b0, 4'd0, 20'd0, 1'b0);
        for (int g = 0; g < 40 && m_left != 0; g++) tick();

        // Load distinct nonzero values, then reset mid-cycle
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'(i), {4'(i), 16'($urandom)} | 20'h1, 1'b0);
            tick();
        end
        drive(1'b0, 4'd0, 20'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        m_reset();
        #1;
        check_all();
        @(posedge clk);
        #1 rst = 1'b0;

        // Full sweep over distinct contents
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'(i), 20'h10000 + 20'(i * 257), 1'b0);
            tick();
        end
        sweep_and_count(cnt);
        check("sweep_busy_cycles", 20'(cnt), 20'd16);

        // Write held during a sweep lands on the first idle cycle
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'(i), 20'hA0000 | 20'(i), 1'b0);
            tick();
        end
        drive(1'b0, 4'd0, 20'd0, 1'b1);
        tick();
        held = 20'h5A5A5;
        drive(1'b1, 4'd7, held, 1'b0);
        for (int g = 0; g < 40 && busy; g++) tick();
        check("held_ready_after_sweep", 20'(wr_ready), 20'd1);
        tick();
        check("held_write_out7", outs[7], held);
        drive(1'b0, 4'd0, 20'd0, 1'b0);

        // Reset around edge E8 of a sweep, then a fresh sweep
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'(i), 20'hC0000 | 20'(i + 1), 1'b0);
            tick();
        end
        drive(1'b0, 4'd0, 20'd0, 1'b1);
        tick();
        clr = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        rst = 1'b1;
        m_reset();
        #1;
        check_all();
        @(posedge clk);
        #1 rst = 1'b0;
        check_all();
        drive(1'b1, 4'd15, 20'h0BEEF, 1'b0);
        tick();
        drive(1'b0, 4'd0, 20'd0, 1'b0);
        sweep_and_count(cnt);
        check("resweep_busy_cycles", 20'(cnt), 20'd16);
        check("resweep_out15", outs[15], 20'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
